// File: rtl/serial_addsub_cmp_pkg.sv
// Shared constants for the serial add/subtract/compare block: mode encoding,
// FSM state type and compare-flag bit positions.
package serial_addsub_cmp_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned FLAG_EQ = 0;
    localparam int unsigned FLAG_LT = 1;
    localparam int unsigned FLAG_GT = 2;
    localparam int unsigned FLAG_W  = 3;

endpackage

// File: rtl/serial_addsub_cmp_if.sv
// Request/response bundle of the serial add/subtract/compare block.
// The master issues start with operands; the slave returns status and results.
interface serial_addsub_cmp_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             eq;
    logic             lt;
    logic             gt;

    modport master (
        output start, a, b, mode, cin,
        input  busy, done, result, cout, ovf, eq, lt, gt
    );

    modport slave (
        input  start, a, b, mode, cin,
        output busy, done, result, cout, ovf, eq, lt, gt
    );
endinterface

// File: rtl/serial_addsub_cmp_chunk.sv
// Combinational CHUNK-bit add/subtract slice with unsigned chunk compare.
// Subtraction is a + ~b + carry; the caller seeds carry with ~borrow_in.
module chunk_addsub_cmp
    import serial_addsub_cmp_pkg::*;
#(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_chunk,
    input  logic [CHUNK-1:0] b_chunk,
    input  logic             carry_in,
    input  logic             mode,
    output logic [CHUNK-1:0] sum,
    output logic             carry_out,
    output logic             carry_msb,
    output logic             gt,
    output logic             lt
);
    logic [CHUNK-1:0] b_eff;
    logic [CHUNK:0]   total;

    always_comb begin
        b_eff     = (mode == MODE_SUB) ? ~b_chunk : b_chunk;
        total     = {1'b0, a_chunk} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry_in};
        sum       = total[CHUNK-1:0];
        carry_out = total[CHUNK];
        // Carry into the MSB recovered from the MSB's own sum equation.
        carry_msb = sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_eff[CHUNK-1];
        gt        = a_chunk > b_chunk;
        lt        = a_chunk < b_chunk;
    end
endmodule

// File: rtl/serial_addsub_cmp.sv
// Multi-cycle add/subtract/compare: WIDTH-bit operands processed CHUNK bits per
// clock, LSB chunk first, with a start/busy/done handshake.
module serial_addsub_cmp
    import serial_addsub_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_addsub_cmp_if.slave   bus
);
    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t state, state_next;

    logic [WIDTH-1:0]  a_q, b_q, result_q;
    logic              mode_q, carry_q, cout_q, ovf_q;
    logic [IDX_W-1:0]  idx_q;
    logic [FLAG_W-1:0] flags_q;

    logic              accept, step, last;
    logic [CHUNK-1:0]  c_sum;
    logic              c_carry, c_msb, c_gt, c_lt;
    logic              gt_next, lt_next;
    logic [WIDTH+CHUNK-1:0] res_cat;

    chunk_addsub_cmp #(.CHUNK(CHUNK)) u_chunk (
        .a_chunk   (a_q[CHUNK-1:0]),
        .b_chunk   (b_q[CHUNK-1:0]),
        .carry_in  (carry_q),
        .mode      (mode_q),
        .sum       (c_sum),
        .carry_out (c_carry),
        .carry_msb (c_msb),
        .gt        (c_gt),
        .lt        (c_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        last       = (idx_q == IDX_W'(N - 1));
        unique case (state)
            IDLE: if (bus.start) begin
                accept     = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A differing chunk overrides the running compare; higher chunks arrive later.
    always_comb begin
        gt_next = flags_q[FLAG_GT];
        lt_next = flags_q[FLAG_LT];
        if (c_gt) begin
            gt_next = 1'b1;
            lt_next = 1'b0;
        end else if (c_lt) begin
            gt_next = 1'b0;
            lt_next = 1'b1;
        end
        res_cat = {c_sum, result_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            mode_q   <= MODE_ADD;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            idx_q    <= '0;
            flags_q  <= '0;
        end else if (accept) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            mode_q   <= bus.mode;
            carry_q  <= (bus.mode == MODE_SUB) ? ~bus.cin : bus.cin;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            idx_q    <= '0;
            flags_q  <= '0;
        end else if (step) begin
            a_q      <= a_q >> CHUNK;
            b_q      <= b_q >> CHUNK;
            result_q <= res_cat[WIDTH+CHUNK-1:CHUNK];
            carry_q  <= c_carry;
            idx_q    <= idx_q + 1'b1;
            flags_q[FLAG_GT] <= gt_next;
            flags_q[FLAG_LT] <= lt_next;
            if (last) begin
                cout_q           <= mode_q ^ c_carry;
                ovf_q            <= c_msb ^ c_carry;
                flags_q[FLAG_EQ] <= ~(gt_next | lt_next);
            end
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
    assign bus.eq     = flags_q[FLAG_EQ];
    assign bus.lt     = flags_q[FLAG_LT];
    assign bus.gt     = flags_q[FLAG_GT];
endmodule

// File: tb/tb_serial_addsub_cmp.sv
// Directed bench for serial_addsub_cmp: a CHUNK=4 instance for the main
// sequence and a CHUNK=16 instance for the single-cycle case.
module tb_serial_addsub_cmp;
    import serial_addsub_cmp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic        mode, cin;

    int ncmp = 0;
    int nerr = 0;

    serial_addsub_cmp_if #(.WIDTH(16)) bus4 ();
    serial_addsub_cmp_if #(.WIDTH(16)) bus16 ();

    assign bus4.start  = start;
    assign bus4.a      = a;
    assign bus4.b      = b;
    assign bus4.mode   = mode;
    assign bus4.cin    = cin;
    assign bus16.start = start;
    assign bus16.a     = a;
    assign bus16.b     = b;
    assign bus16.mode  = mode;
    assign bus16.cin   = cin;

    serial_addsub_cmp #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    serial_addsub_cmp #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tm, input logic tc);
        a     = ta;
        b     = tb_v;
        mode  = tm;
        cin   = tc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (!bus4.done && lat < 20) begin
            if (bus4.busy) busy_n++;
            tick();
            lat++;
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] r, input logic co,
                           input logic ov, input logic e, input logic l, input logic g);
        chk({tag, ".result"}, 32'(bus4.result), 32'(r));
        chk({tag, ".cout"},   32'(bus4.cout),   32'(co));
        chk({tag, ".ovf"},    32'(bus4.ovf),    32'(ov));
        chk({tag, ".eqltgt"}, 32'({bus4.eq, bus4.lt, bus4.gt}), 32'({e, l, g}));
    endtask

    initial begin
        int lat, busy_n, n_done;
        logic [15:0] r_save;

        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; mode = MODE_ADD; cin = 1'b0;
        #12;
        chk("reset.ctl4",  32'({bus4.busy, bus4.done, bus4.cout, bus4.ovf, bus4.eq, bus4.lt, bus4.gt}), 32'd0);
        chk("reset.res4",  32'(bus4.result), 32'd0);
        chk("reset.ctl16", 32'({bus16.busy, bus16.done, bus16.result}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic add with latency and busy-length checks
        launch(16'h1234, 16'h0FFF, MODE_ADD, 1'b0);
        wait_done(lat, busy_n);
        chk("add.latency", 32'(lat), 32'd4);
        chk("add.busy_cycles", 32'(busy_n), 32'd4);
        chk_out("add", 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("add.done_pulse", 32'(bus4.done), 32'd0);

        launch(16'hFFFF, 16'h0001, MODE_ADD, 1'b0);
        wait_done(lat, busy_n);
        chk_out("carry", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        launch(16'h7FFF, 16'h0001, MODE_ADD, 1'b0);
        wait_done(lat, busy_n);
        chk_out("ovf", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();

        launch(16'h0006, 16'h0003, MODE_SUB, 1'b1);
        wait_done(lat, busy_n);
        chk_out("sub_gt", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        launch(16'h0003, 16'h0005, MODE_SUB, 1'b0);
        wait_done(lat, busy_n);
        chk_out("sub_lt", 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        launch(16'h00A5, 16'h00A5, MODE_SUB, 1'b0);
        wait_done(lat, busy_n);
        chk_out("equal", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // Start pulsed mid-RUN with different operands must be ignored
        launch(16'h1234, 16'h0FFF, MODE_ADD, 1'b0);
        n_done = 0;
        r_save = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                a = 16'h5555; b = 16'h1111; mode = MODE_SUB; start = 1'b1;
            end
            if (i == 2) start = 1'b0;
            if (bus4.done) begin
                n_done++;
                r_save = bus4.result;
            end
            tick();
        end
        chk("midrun.done_count", 32'(n_done), 32'd1);
        chk("midrun.result", 32'(r_save), 32'h2233);
        chk("midrun.idle", 32'(bus4.busy), 32'd0);

        // Start held through DONE: second op begins with no idle cycle
        launch(16'hFFFF, 16'h0001, MODE_ADD, 1'b0);
        tick(); tick(); tick();
        a = 16'h7FFF; b = 16'h0001; mode = MODE_ADD; cin = 1'b0; start = 1'b1;
        tick();
        chk("b2b.first_done", 32'(bus4.done), 32'd1);
        chk_out("b2b.first", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        chk("b2b.no_idle", 32'(bus4.busy), 32'd1);
        wait_done(lat, busy_n);
        chk("b2b.latency", 32'(lat), 32'd4);
        chk_out("b2b.second", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();

        // Reset during chunk 2 discards the operation
        launch(16'h1234, 16'h0FFF, MODE_ADD, 1'b0);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("rst.ctl", 32'({bus4.busy, bus4.done, bus4.cout, bus4.ovf, bus4.eq, bus4.lt, bus4.gt}), 32'd0);
        chk("rst.result", 32'(bus4.result), 32'd0);
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus4.done) n_done++;
            tick();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (bus4.done || bus4.busy) n_done++;
            tick();
        end
        chk("rst.no_done", 32'(n_done), 32'd0);
        launch(16'h0003, 16'h0005, MODE_SUB, 1'b0);
        wait_done(lat, busy_n);
        chk("rst.after_latency", 32'(lat), 32'd4);
        chk_out("rst.after", 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();

        // CHUNK=WIDTH instance: done one cycle after the accepting edge
        launch(16'h1234, 16'h0FFF, MODE_ADD, 1'b0);
        chk("w16.busy", 32'({bus16.busy, bus16.done}), 32'b10);
        tick();
        chk("w16.done", 32'(bus16.done), 32'd1);
        chk("w16.result", 32'(bus16.result), 32'h2233);
        chk("w16.flags", 32'({bus16.cout, bus16.ovf, bus16.eq, bus16.lt, bus16.gt}), 32'b00001);
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
